// File: rtl/pe_relay_pkg.sv
// Shared constants for the PE relay tile: default widths, occupancy width helper
// and the channel index map of the E/N/S links.
package pe_relay_pkg;

  localparam int DATA_W_DEF = 130;
  localparam int CNT_W_DEF  = 32;

  localparam int CH_EAST  = 0;
  localparam int CH_NORTH = 1;
  localparam int CH_SOUTH = 2;

  // Fill level must represent 0..DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pe_relay_fifo.sv
// One relay channel: DEPTH-entry FIFO with valid/ready ingress; the pop strobe is
// supplied by the top, which owns egress gating.
module pe_relay_fifo
  import pe_relay_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int OCC_W  = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_nempty,
  output logic [OCC_W-1:0]  o_count
);

  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_push;

  // Ready depends only on stored state, so no path exists from downstream ready.
  assign o_ready  = ~reset & (r_count < FULL_LVL);
  assign w_push   = i_valid & o_ready;
  assign o_data   = r_mem[r_rd_ptr];
  assign o_nempty = (r_count != '0);
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_relay_pipe.sv
// Relay tile carrying NUM_CH independent FIFO-buffered channels across an unused PE slot.
// Optional per-channel egress transfer counters are built when PE_RELAY_CNT_EN is defined.
module pe_relay_pipe
  import pe_relay_pkg::*;
#(
  parameter int  NUM_CH = 3,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = 2,
  parameter int  CNT_W  = CNT_W_DEF,
  localparam int OCC_W  = occ_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*OCC_W-1:0]  occ
`ifdef PE_RELAY_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]  xfer_cnt
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_chk
    $error("pe_relay_pipe: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic [NUM_CH-1:0] w_nempty;
  logic [NUM_CH-1:0] w_pop;

  // ap_start only masks egress; queued words stay put while it is low.
  assign out_valid = w_nempty & {NUM_CH{ap_start}};
  assign w_pop     = out_valid & out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pe_relay_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_data   (in_data[g*DATA_W +: DATA_W]),
      .i_valid  (in_valid[g]),
      .o_ready  (in_ready[g]),
      .i_pop    (w_pop[g]),
      .o_data   (out_data[g*DATA_W +: DATA_W]),
      .o_nempty (w_nempty[g]),
      .o_count  (occ[g*OCC_W +: OCC_W])
    );

`ifdef PE_RELAY_CNT_EN
    logic [CNT_W-1:0] r_xfer;

    always_ff @(posedge clk) begin
      if (reset)         r_xfer <= '0;
      else if (w_pop[g]) r_xfer <= r_xfer + 1'b1;
    end

    assign xfer_cnt[g*CNT_W +: CNT_W] = r_xfer;
`endif
  end

endmodule

// File: tb/tb_pe_relay_pipe.sv
// Directed bench for pe_relay_pipe: cycle-vector table for single-word, back-pressure
// and ap_start gating, plus hand sequences for reset, streaming and reset mid-stream.
module tb_pe_relay_pipe;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 130;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 32;
  localparam int OCC_W  = 2;
  localparam int NV     = 17;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     ap_start;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*OCC_W-1:0]  occ;
`ifdef PE_RELAY_CNT_EN
  logic [NUM_CH*CNT_W-1:0]  xfer_cnt;
`endif

  pe_relay_pipe #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occ       (occ)
`ifdef PE_RELAY_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ap;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ov;
    logic [2:0]  ir;
    logic [5:0]  occ;
    logic [31:0] od0, od1, od2;
  } vec_t;

  vec_t tbl [NV];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [NUM_CH*DATA_W-1:0] act,
                     input logic [NUM_CH*DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] word(input int c, input int k);
    return {2'(c), 64'(k * 7 + 1), 64'(k)};
  endfunction

  initial begin
    logic [31:0]              od [3];
    logic [NUM_CH*DATA_W-1:0] exp_d;
    int                       rx [3];

    //            ap    iv      ordy    d0        d1      d2       ov      ir      occ        od0       od1     od2
    tbl[0]  = '{1'b1, 3'b001, 3'b111, 32'h1234, 32'h0, 32'h0,  3'b000, 3'b111, 6'b000000, 32'h0,    32'h0,  32'h0};
    tbl[1]  = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b001, 3'b111, 6'b000001, 32'h1234, 32'h0,  32'h0};
    tbl[2]  = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b000, 3'b111, 6'b000000, 32'h0,    32'h0,  32'h0};
    tbl[3]  = '{1'b1, 3'b010, 3'b101, 32'h0,    32'hA, 32'h0,  3'b000, 3'b111, 6'b000000, 32'h0,    32'h0,  32'h0};
    tbl[4]  = '{1'b1, 3'b010, 3'b101, 32'h0,    32'hB, 32'h0,  3'b010, 3'b111, 6'b000100, 32'h0,    32'hA,  32'h0};
    tbl[5]  = '{1'b1, 3'b010, 3'b101, 32'h0,    32'hC, 32'h0,  3'b010, 3'b101, 6'b001000, 32'h0,    32'hA,  32'h0};
    tbl[6]  = '{1'b1, 3'b010, 3'b101, 32'h0,    32'hC, 32'h0,  3'b010, 3'b101, 6'b001000, 32'h0,    32'hA,  32'h0};
    tbl[7]  = '{1'b1, 3'b010, 3'b111, 32'h0,    32'hC, 32'h0,  3'b010, 3'b101, 6'b001000, 32'h0,    32'hA,  32'h0};
    tbl[8]  = '{1'b1, 3'b010, 3'b111, 32'h0,    32'hC, 32'h0,  3'b010, 3'b111, 6'b000100, 32'h0,    32'hB,  32'h0};
    tbl[9]  = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b010, 3'b111, 6'b000100, 32'h0,    32'hC,  32'h0};
    tbl[10] = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b000, 3'b111, 6'b000000, 32'h0,    32'h0,  32'h0};
    tbl[11] = '{1'b0, 3'b100, 3'b111, 32'h0,    32'h0, 32'h21, 3'b000, 3'b111, 6'b000000, 32'h0,    32'h0,  32'h0};
    tbl[12] = '{1'b0, 3'b100, 3'b111, 32'h0,    32'h0, 32'h22, 3'b000, 3'b111, 6'b010000, 32'h0,    32'h0,  32'h0};
    tbl[13] = '{1'b0, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b000, 3'b011, 6'b100000, 32'h0,    32'h0,  32'h0};
    tbl[14] = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b100, 3'b011, 6'b100000, 32'h0,    32'h0,  32'h21};
    tbl[15] = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b100, 3'b111, 6'b010000, 32'h0,    32'h0,  32'h22};
    tbl[16] = '{1'b1, 3'b000, 3'b111, 32'h0,    32'h0, 32'h0,  3'b000, 3'b111, 6'b000000, 32'h0,    32'h0,  32'h0};

    // Reset then idle
    reset = 1'b1; ap_start = 1'b0; in_valid = '0; out_ready = '0; in_data = '0;
    step(); step();
    chk("rst in_ready", in_ready, 3'b000);
    chk("rst out_valid", out_valid, 3'b000);
    chk("rst occ", occ, 6'b0);
    chk("rst out_data", out_data, '0);
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 3'b111);
    chk("post-rst out_valid", out_valid, 3'b000);

    // Single word, back-pressure, ap_start gate
    for (int i = 0; i < NV; i++) begin
      ap_start  = tbl[i].ap;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = {130'(tbl[i].d2), 130'(tbl[i].d1), 130'(tbl[i].d0)};
      #1;
      chk($sformatf("v%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("v%0d occ", i), occ, tbl[i].occ);
      od[0] = tbl[i].od0; od[1] = tbl[i].od1; od[2] = tbl[i].od2;
      for (int c = 0; c < NUM_CH; c++)
        if (tbl[i].ov[c])
          chk($sformatf("v%0d out_data ch%0d", i, c), out_data[c*DATA_W +: DATA_W], 130'(od[c]));
      step();
    end

    // Streaming, starting from a fresh reset so counters begin at zero
    in_valid = '0; reset = 1'b1;
    step();
    reset = 1'b0; ap_start = 1'b1; out_ready = 3'b111;
    for (int c = 0; c < NUM_CH; c++) rx[c] = 0;
    for (int k = 0; k <= 100; k++) begin
      in_valid = (k < 100) ? 3'b111 : 3'b000;
      for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = word(c, k);
      #1;
      if (k > 0) begin
        exp_d = {word(2, k - 1), word(1, k - 1), word(0, k - 1)};
        chk($sformatf("stream%0d valid/ready", k), {out_valid, in_ready}, 6'b111111);
        chk($sformatf("stream%0d data", k), out_data, exp_d);
      end
      for (int c = 0; c < NUM_CH; c++) if (out_valid[c] && out_ready[c]) rx[c]++;
      step();
    end
    chk("stream drained", out_valid, 3'b000);
    chk("stream rx count", {32'(rx[2]), 32'(rx[1]), 32'(rx[0])}, {32'd100, 32'd100, 32'd100});
`ifdef PE_RELAY_CNT_EN
    chk("xfer_cnt", xfer_cnt, {32'd100, 32'd100, 32'd100});
`endif

    // Reset mid-stream with two words parked on ch0
    ap_start = 1'b0; in_valid = 3'b001; in_data = '0;
    in_data[DATA_W-1:0] = 130'h66;
    step();
    in_data[DATA_W-1:0] = 130'h77;
    step();
    in_valid = '0;
    #1;
    chk("mid occ before rst", occ, 6'b000010);
    reset = 1'b1; ap_start = 1'b1;
    #1;
    chk("mid in_ready in rst", in_ready, 3'b000);
    step();
    chk("mid occ after rst", occ, 6'b0);
    chk("mid out_valid after rst", out_valid, 3'b000);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mid idle%0d", k), {out_valid, out_data}, '0);
`ifdef PE_RELAY_CNT_EN
      chk($sformatf("mid xfer%0d", k), xfer_cnt, '0);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
